uart_rx_fifo: RTL

- Parametrised UART receiver; successor to the fixed 8N1 receiver in the host-load path.
- Generalised in baud divisor, data width and FIFO depth.
- Adds input synchronisation, start-glitch rejection, stop-bit framing check, overrun detection and a buffered valid/ready output.
- Sits between the board RX pin and the instruction/data loader, which drains bytes at its own pace.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 78 +++++++
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default baud divisor, parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // XOR of all bits; callers zero-extend narrower words to 9 bits.
    function automatic logic ones_parity(input logic [8:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO (power-of-two DEPTH); a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic                        do_push_s, do_pop_s;

    assign empty_o   = (level_q == LVL_ZERO);
    assign full_o    = (level_q == LVL_FULL);
    assign level_o   = level_q;
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign data_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_q];

    // Next-state pointers and occupancy.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push_s) begin
            wr_d = wr_q + PTR_ONE;
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + PTR_ONE;
        end else begin
            rd_d = rd_q;
        end
        if (do_push_s && !do_pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (do_pop_s && !do_push_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= LVL_ZERO;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            if (do_push_s) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with input synchroniser, glitch rejection, framing
// and overrun detection, buffered by a show-ahead FIFO. Optional parity: UART_RX_PARITY_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          valid,
    input  logic                          ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TICK_T   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_T   = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs_s;
    rx_state_e              state_q;
    logic [TMR_W-1:0]       timer_q;
    logic [IDX_W-1:0]       index_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   frame_err_q, overrun_q;
    logic                   tick_s, push_s, pop_s, parity_bad_s;
    logic                   fifo_full_s, fifo_empty_s;

    assign rs_s   = sync_q[SYNC_STAGES-1];
    assign tick_s = (timer_q == TICK_T);

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, parity_err_q;
    assign parity_bad_s = ones_parity(9'(shreg_q)) ^ par_bit_q ^ PARITY_ODD;
    assign parity_err   = parity_err_q;
`else
    assign parity_bad_s = 1'b0;
`endif

    // A word is offered to the FIFO only in a clean stop-sample cycle.
    assign push_s    = (state_q == ST_STOP) && tick_s && rs_s && !parity_bad_s;
    assign pop_s     = valid && ready;
    assign valid     = !fifo_empty_s;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Metastability synchroniser; idles high so reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // Receive FSM with bit timer, bit index, shift register and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            index_q     <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= push_s && fifo_full_s && !pop_s;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (!rs_s) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_q == HALF_T) begin
                        timer_q <= '0;
                        index_q <= '0;
                        state_q <= rs_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        timer_q          <= '0;
                        shreg_q[index_q] <= rs_s;
                        if (index_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            index_q <= index_q + IDX_ONE;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        timer_q   <= '0;
                        par_bit_q <= rs_s;
                        state_q   <= ST_STOP;
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        timer_q <= '0;
                        if (!rs_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= parity_bad_s;
`endif
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                // Hold off until the line returns high so a stuck-low line yields one error.
                ST_BREAK: begin
                    timer_q <= '0;
                    if (rs_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (shreg_q),
        .pop_i   (pop_s),
        .data_o  (data_out),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level)
    );

endmodule
